// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: shifts a latched operand one bit per clock (left, logical
// right or arithmetic right) and presents the result with a one-cycle done pulse.
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic             arith,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               arith_q, arith_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   step_s;

    // Single-position shift; the arithmetic fill only applies to right shifts.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [WIDTH-1:0] v,
        input logic             right,
        input logic             ar
    );
        logic fill;
        fill = right & ar & v[WIDTH-1];
        if (right) begin
            shift_one = {fill, v[WIDTH-1:1]};
        end else begin
            shift_one = {v[WIDTH-2:0], 1'b0};
        end
    endfunction

    assign step_s = shift_one(shreg_q, dir_q, arith_q);

    // Next-state and datapath decode.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = din;
                    cnt_d   = amount;
                    dir_d   = dir;
                    arith_d = arith;
                    if (amount == CNT_ZERO) begin
                        state_d = ST_DONE;
                        dout_d  = din;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shreg_d = step_s;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    dout_d  = step_s;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status flags are registered from the next state so they align with state_q.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= {WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
            dout_q  <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed self-checking bench for seq_shift_unit (WIDTH=8, AMT_W=3).
module tb_seq_shift_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       dir;
    logic       arith;
    logic [2:0] amount;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] dout;

    int n_checks = 0;
    int n_fail   = 0;

    seq_shift_unit #(.WIDTH(8), .AMT_W(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .dir    (dir),
        .arith  (arith),
        .amount (amount),
        .din    (din),
        .busy   (busy),
        .done   (done),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation, scramble inputs after E0, then check latency, busy span and result.
    task automatic run_op(input string tag, input logic [7:0] d, input logic dr,
                          input logic ar, input logic [2:0] amt, input logic [7:0] exp);
        int k;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        din = d; dir = dr; arith = ar; amount = amt; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; din = ~d; dir = ~dr; arith = ~ar; amount = ~amt;
        k = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
            end else begin
                k++;
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, k, 32'(amt));
        check({tag, "_busy_cycles"}, busy_cnt, 32'(amt) + 32'd1);
        check({tag, "_dout"}, 32'(dout), 32'(exp));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_dout_hold"}, 32'(dout), 32'(exp));
    endtask

    initial begin
        int pulses;
        int first_idx;
        int last_idx;
        int gap_bad;
        logic [7:0] held;

        rst_n = 1'b0; start = 1'b0; dir = 1'b0; arith = 1'b0; amount = 3'd0; din = 8'h00;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("lsr2",  8'b1011_0010, 1'b1, 1'b0, 3'd2, 8'b0010_1100);
        run_op("asr2",  8'b1011_0010, 1'b1, 1'b1, 3'd2, 8'b1110_1100);
        run_op("lsl3",  8'b1011_0010, 1'b0, 1'b1, 3'd3, 8'b1001_0000);
        run_op("amt0",  8'h5A,        1'b0, 1'b0, 3'd0, 8'h5A);
        run_op("asr7",  8'h80,        1'b1, 1'b1, 3'd7, 8'hFF);
        run_op("lsr7",  8'h80,        1'b1, 1'b0, 3'd7, 8'h01);

        // Reset in the middle of a shift discards the operation immediately.
        @(negedge clk);
        din = 8'hB2; dir = 1'b1; arith = 1'b0; amount = 3'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("midrst_quiet", pulses, 32'd0);

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        din = 8'h0F; dir = 1'b0; arith = 1'b0; amount = 3'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        din = 8'hFF; amount = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; held = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                pulses++;
                held = dout;
            end
            @(negedge clk);
        end
        check("rej_pulses", pulses, 32'd1);
        check("rej_dout", 32'(held), 32'hF0);
        check("rej_final_dout", 32'(dout), 32'hF0);

        // Start held high: an op completes every 3 cycles, start ignored during DONE.
        din = 8'h81; dir = 1'b0; arith = 1'b0; amount = 3'd1; start = 1'b1;
        pulses = 0; first_idx = -1; last_idx = -1; gap_bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first_idx < 0) first_idx = i;
                else if (i - last_idx != 3) gap_bad++;
                last_idx = i;
                if (dout !== 8'h02) gap_bad++;
            end else if (first_idx >= 0 && dout !== 8'h02) begin
                gap_bad++;
            end
        end
        start = 1'b0;
        check("b2b_pulses", pulses, 32'd4);
        check("b2b_first", first_idx, 32'd1);
        check("b2b_spacing", gap_bad, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
